// File: rtl/traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_controller
// Brief    : Sensor-actuated N-phase signal controller with latched ped walk
//            and round-robin demand skipping. EMERGENCY_PREEMPT_EN adds preemption.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_controller #(
    parameter int N_PHASES    = 2,
    parameter int MIN_GREEN   = 8,
    parameter int MAX_GREEN   = 32,
    parameter int YELLOW_TIME = 4,
    parameter int ALLRED_TIME = 2,
    parameter int WALK_TIME   = 6,
    parameter int TW          = 6
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_PHASES-1:0]         veh_sensor,
    input  logic [N_PHASES-1:0]         ped_button,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic                        emg_req,
    input  logic [$clog2(N_PHASES)-1:0] emg_phase,
    output logic                        emg_active,
`endif
    output logic [3*N_PHASES-1:0]       light,
    output logic [N_PHASES-1:0]         ped_walk,
    output logic [$clog2(N_PHASES)-1:0] active_phase,
    output logic [N_PHASES-1:0]         ped_pending
);

    localparam int AW = $clog2(N_PHASES);
    localparam logic [TW-1:0]         c_allred_last = TW'(ALLRED_TIME - 1);
    localparam logic [TW-1:0]         c_yellow_last = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0]         c_walk_last   = TW'(WALK_TIME - 1);
    localparam logic [TW-1:0]         c_min_last    = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0]         c_max_last    = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0]         c_timer_sat   = TW'(MAX_GREEN);
    localparam logic [N_PHASES-1:0]   c_one         = N_PHASES'(1);
    localparam logic [3*N_PHASES-1:0] c_all_red     = {N_PHASES{3'b100}};

    typedef enum logic [1:0] {
        c_st_allred = 2'd0,
        c_st_green  = 2'd1,
        c_st_yellow = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [TW-1:0]         r_timer, w_timer_nxt;
    logic [AW-1:0]         r_active, w_active_nxt, w_rr_phase, w_next_phase;
    logic                  r_first;
    logic [3*N_PHASES-1:0] r_light, w_light_nxt;
    logic [N_PHASES-1:0]   r_ped_walk, w_walk_nxt, r_pending, w_pend_nxt;
    logic [N_PHASES-1:0]   w_demand, w_active_oh, w_next_oh, w_ped_req;
    logic                  w_other, w_walk_done, w_veh_active;
    logic                  w_green_exit, w_enter_green, w_force_exit, w_hold_green;
    int                    w_idx;

    assign w_demand     = veh_sensor | r_pending;
    assign w_active_oh  = c_one << r_active;
    assign w_next_oh    = c_one << w_next_phase;
    assign w_ped_req    = r_pending | ped_button;
    assign w_other      = |(w_demand & ~w_active_oh);
    assign w_veh_active = |(veh_sensor & w_active_oh);
    assign w_walk_done  = ~|r_ped_walk;

    // Search downward so the nearest phase after the active one wins.
    always_comb begin
        w_rr_phase = r_active;
        w_idx      = 0;
        for (int k = N_PHASES; k >= 1; k--) begin
            w_idx = int'(r_active) + k;
            if (w_idx >= N_PHASES) w_idx = w_idx - N_PHASES;
            if (|(w_demand & (c_one << w_idx))) w_rr_phase = AW'(w_idx);
        end
    end

`ifdef EMERGENCY_PREEMPT_EN
    logic w_emg_valid;
    logic r_emg_active;

    assign w_emg_valid  = emg_req && (int'(emg_phase) < N_PHASES);
    assign w_force_exit = w_emg_valid && (r_active != emg_phase);
    assign w_hold_green = w_emg_valid && (r_active == emg_phase);
    assign w_next_phase = w_emg_valid ? emg_phase : (r_first ? '0 : w_rr_phase);
    assign emg_active   = r_emg_active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_emg_active <= 1'b0;
        else          r_emg_active <= w_emg_valid;
    end
`else
    assign w_force_exit = 1'b0;
    assign w_hold_green = 1'b0;
    assign w_next_phase = r_first ? '0 : w_rr_phase;
`endif

    // A timer already saturated past MAX_GREEN-1 still counts as maxed out.
    assign w_green_exit = w_force_exit |
                          (!w_hold_green && w_walk_done && w_other &&
                           (r_timer >= c_min_last) &&
                           (!w_veh_active || (r_timer >= c_max_last)));

    always_comb begin
        w_state_nxt   = r_state;
        w_active_nxt  = r_active;
        w_enter_green = 1'b0;
        case (r_state)
            c_st_allred: begin
                if (r_timer == c_allred_last) begin
                    w_state_nxt   = c_st_green;
                    w_active_nxt  = w_next_phase;
                    w_enter_green = 1'b1;
                end
            end
            c_st_green: begin
                if (w_green_exit) w_state_nxt = c_st_yellow;
            end
            c_st_yellow: begin
                if (r_timer == c_yellow_last) w_state_nxt = c_st_allred;
            end
            default: w_state_nxt = c_st_allred;
        endcase
    end

    always_comb begin
        if (w_state_nxt != r_state)    w_timer_nxt = '0;
        else if (r_timer >= c_timer_sat) w_timer_nxt = r_timer;
        else                           w_timer_nxt = r_timer + TW'(1);
    end

    always_comb begin
        w_walk_nxt = r_ped_walk;
        if (w_enter_green)
            w_walk_nxt = (|(w_ped_req & w_next_oh)) ? w_next_oh : '0;
        else if ((w_state_nxt != c_st_green) || (r_timer == c_walk_last))
            w_walk_nxt = '0;
    end

    for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_phase
        assign w_light_nxt[3*gi +: 3] =
            (w_active_nxt != AW'(gi))     ? 3'b100 :
            (w_state_nxt == c_st_green)   ? 3'b001 :
            (w_state_nxt == c_st_yellow)  ? 3'b010 : 3'b100;

        // Entry clear beats a same-cycle press; presses during own walk are absorbed.
        assign w_pend_nxt[gi] =
            (w_enter_green && (w_next_phase == AW'(gi))) ? 1'b0 :
            ((r_state == c_st_green) && (r_active == AW'(gi)) && r_ped_walk[gi]) ? r_pending[gi] :
            (r_pending[gi] | ped_button[gi]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_st_allred;
            r_timer    <= '0;
            r_active   <= '0;
            r_first    <= 1'b1;
            r_light    <= c_all_red;
            r_ped_walk <= '0;
            r_pending  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_active   <= w_active_nxt;
            r_first    <= r_first & ~w_enter_green;
            r_light    <= w_light_nxt;
            r_ped_walk <= w_walk_nxt;
            r_pending  <= w_pend_nxt;
        end
    end

    assign light        = r_light;
    assign ped_walk     = r_ped_walk;
    assign active_phase = r_active;
    assign ped_pending  = r_pending;

endmodule
`default_nettype wire
